// File: rtl/cargador_programa_pkg.sv
// ---------------------------------------------------------------------------
// cargador_programa_pkg
// Shared definitions for the program loader: FSM state encoding, the width
// of the word-count header and the number of bytes that make one
// instruction word.
// ---------------------------------------------------------------------------
package cargador_programa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/ensamblador_palabra.sv
// ---------------------------------------------------------------------------
// ensamblador_palabra
// Assembles big-endian 32-bit words from a byte stream. Each shifted byte
// enters at the low end, so the first byte of a word ends up in [31:24].
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous reset, active low (clears word and counter)
//   i_clear         restart the byte counter for a new load
//   i_shift         shift i_byte in this cycle
//   i_byte          stream byte
//   o_word          assembled word (holds its value between shifts)
//   o_word_complete high in the cycle the last byte of a word is shifted in
// ---------------------------------------------------------------------------
module ensamblador_palabra
    import cargador_programa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_complete
);

    logic [WORD_W-1:0]     r_word;
    logic [BYTE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= {r_word[WORD_W-9:0], i_byte};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Flag is combinational so the FSM can enter WRITE on the same edge
    // that the last byte lands in the shift register.
    assign o_word_complete = i_shift &&
                             (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign o_word          = r_word;

endmodule

// File: rtl/cargador_programa.sv
// ---------------------------------------------------------------------------
// cargador_programa
// Loads a program into instruction memory from a byte stream while holding
// the CPU datapath in reset. Stream: 16-bit big-endian word count N, then
// 4*N bytes of big-endian instructions. Lengths of 0 or above MAX_WORDS are
// rejected.
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   i_start         begin a load (honoured in IDLE, DONE and ERROR)
//   i_byte_valid    stream byte present
//   i_byte          stream byte
//   o_byte_ready    byte accepted this cycle when i_byte_valid is also 1
//   o_imem_we       instruction-memory write strobe (one cycle per word)
//   o_imem_addr     byte address, BASE_ADDR + 4*k
//   o_imem_data     instruction word being written
//   o_cpu_hold      hold CPU in reset (low only after a successful load)
//   o_busy          load in progress
//   o_done          load completed
//   o_error         load rejected for bad length
// ---------------------------------------------------------------------------
module cargador_programa
    import cargador_programa_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_data,
    output logic        o_cpu_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_len_hi;
    logic [HDR_W-1:0]   r_nwords;
    logic [HDR_W-1:0]   r_k;
    logic [31:0]        r_addr;
    logic               r_byte_ready;
    logic               r_imem_we;
    logic               r_cpu_hold;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic               w_accept;
    logic               w_start_ok;
    logic               w_shift;
    logic               w_word_complete;
    logic [HDR_W-1:0]   w_len;
    logic               w_len_bad;
    logic               w_last_word;
    logic [WORD_W-1:0]  w_word;

    assign w_accept    = i_byte_valid && r_byte_ready;
    assign w_start_ok  = i_start && ((r_state == ST_IDLE) ||
                                     (r_state == ST_DONE) ||
                                     (r_state == ST_ERROR));
    assign w_shift     = w_accept && (r_state == ST_DATA);
    assign w_len       = {r_len_hi, i_byte};
    assign w_len_bad   = (w_len == '0) || ({16'd0, w_len} > 32'(MAX_WORDS));
    assign w_last_word = (r_k == (r_nwords - 16'd1));

    ensamblador_palabra u_ensamblador (
        .clk             (clk),
        .reset           (reset),
        .i_clear         (w_start_ok),
        .i_shift         (w_shift),
        .i_byte          (i_byte),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (i_start) w_next = ST_LEN_HI;
            ST_LEN_HI:                  if (w_accept) w_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (w_accept) w_next = w_len_bad ? ST_ERROR : ST_DATA;
            end
            ST_DATA:                    if (w_word_complete) w_next = ST_WRITE;
            ST_WRITE:                   w_next = w_last_word ? ST_DONE : ST_DATA;
            default:                    w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe (e.g. o_imem_we is high for the WRITE
    // cycle that follows the 4th byte).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_len_hi     <= '0;
            r_nwords     <= '0;
            r_k          <= '0;
            r_addr       <= BASE_ADDR;
            r_byte_ready <= 1'b0;
            r_imem_we    <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next == ST_LEN_HI) || (w_next == ST_LEN_LO) ||
                            (w_next == ST_DATA);
            r_imem_we    <= (w_next == ST_WRITE);
            r_cpu_hold   <= (w_next != ST_DONE);
            r_busy       <= (w_next == ST_LEN_HI) || (w_next == ST_LEN_LO) ||
                            (w_next == ST_DATA)   || (w_next == ST_WRITE);
            r_done       <= (w_next == ST_DONE);
            r_error      <= (w_next == ST_ERROR);

            if (w_start_ok) begin
                r_nwords <= '0;
                r_k      <= '0;
                r_addr   <= BASE_ADDR;
            end

            case (r_state)
                ST_LEN_HI: if (w_accept) r_len_hi <= i_byte;
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_nwords <= w_len;
                        r_k      <= '0;
                        r_addr   <= BASE_ADDR;
                    end
                end
                ST_WRITE: begin
                    // Address wraps naturally modulo 2^32.
                    if (!w_last_word) begin
                        r_k    <= r_k + 16'd1;
                        r_addr <= r_addr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_data  = w_word;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_cargador_programa.sv
module tb_cargador_programa;

    localparam int          MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        o_byte_ready, o_imem_we, o_cpu_hold, o_busy, o_done, o_error;
    logic [31:0] o_imem_addr, o_imem_data;

    cargador_programa #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_cpu_hold   (o_cpu_hold),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cycle;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write,
    // including the cycle it was predicted for.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (o_imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got addr %h data %h expected no write", o_imem_addr, o_imem_data);
            end else begin
                e = sb.pop_front();
                chk("write_addr", o_imem_addr, e.addr);
                chk("write_data", o_imem_data, e.data);
                chk("write_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rg(input int lo, input int hi);
        return (hi <= lo) ? lo : int'($urandom_range(hi, lo));
    endfunction

    // Called at a negedge; returns at a negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap,
                             input bit push, input logic [31:0] ea, input logic [31:0] ed);
        wr_t e;
        int  t = 0;
        i_byte_valid = 1'b1;
        i_byte       = b;
        while (o_byte_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (o_byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got ready=0 expected ready=1 within 64 cycles");
            i_byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        if (push) begin
            e.addr  = ea;
            e.data  = ed;
            e.cycle = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        if (gap > 0) begin
            i_byte_valid = 1'b0;
            i_byte       = 8'($urandom);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic do_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_end(input bit exp_err);
        int t = 0;
        while (o_done !== 1'b1 && o_error !== 1'b1 && t < 32) begin
            @(negedge clk);
            t++;
        end
        chk("end_done",  o_done,  32'(!exp_err));
        chk("end_error", o_error, 32'(exp_err));
        chk("end_hold",  o_cpu_hold, 32'(exp_err));
        chk("end_busy",  o_busy,  0);
        chk("end_ready", o_byte_ready, 0);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    // Reference: word w goes to BASE + 4*w, bytes sent MSB first.
    task automatic run_load(input logic [15:0] n, input int gmin, input int gmax);
        bit bad;
        logic [7:0] by;
        bad = (n == 16'd0) || (int'(n) > MAXW);
        do_start();
        chk("busy_after_start",  o_busy, 1);
        chk("hold_after_start",  o_cpu_hold, 1);
        chk("done_after_start",  o_done, 0);
        chk("error_after_start", o_error, 0);
        send_byte(n[15:8], rg(gmin, gmax), 1'b0, 0, 0);
        send_byte(n[7:0],  rg(gmin, gmax), 1'b0, 0, 0);
        if (!bad) begin
            for (int w = 0; w < int'(n); w++) begin
                for (int b = 0; b < 4; b++) begin
                    by = wq[w][31-8*b -: 8];
                    send_byte(by, rg(gmin, gmax), b == 3, BASE + 32'(4*w), wq[w]);
                end
            end
        end
        i_byte_valid = 1'b0;
        wait_end(bad);
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        // Reset held for two edges
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hold",  o_cpu_hold, 1);
        chk("rst_we",    o_imem_we, 0);
        chk("rst_addr",  o_imem_addr, BASE);
        chk("rst_data",  o_imem_data, 0);
        chk("rst_ready", o_byte_ready, 0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_done",  o_done, 0);
        chk("rst_error", o_error, 0);
        reset = 1'b1;
        @(negedge clk);

        // Bytes offered in IDLE are not consumed
        i_byte_valid = 1'b1;
        i_byte = 8'h77;
        repeat (2) @(negedge clk);
        chk("idle_ready", o_byte_ready, 0);
        chk("idle_busy",  o_busy, 0);
        i_byte_valid = 1'b0;

        // Reference program, back-to-back bytes
        wq.delete();
        wq.push_back(32'h2008_0005);
        wq.push_back(32'h0000_0000);
        run_load(16'd2, 0, 0);

        // Bytes offered in DONE are not consumed and DONE persists
        i_byte_valid = 1'b1;
        i_byte = 8'h55;
        repeat (2) @(negedge clk);
        chk("done_ready", o_byte_ready, 0);
        chk("done_stays", o_done, 1);
        i_byte_valid = 1'b0;

        // Bad lengths
        run_load(16'd0, 0, 0);
        i_byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("error_ready", o_byte_ready, 0);
        chk("error_stays", o_error, 1);
        i_byte_valid = 1'b0;
        run_load(16'h0101, 0, 0);
        run_load(16'(MAXW + 1), 1, 2);

        // N=1 with valid toggling between every byte
        fill_random(1);
        run_load(16'd1, 1, 1);

        // Reset in the middle of a word, then a clean single-word load
        do_start();
        send_byte(8'h00, 0, 1'b0, 0, 0);
        send_byte(8'h01, 0, 1'b0, 0, 0);
        send_byte(8'h11, 0, 1'b0, 0, 0);
        send_byte(8'h22, 0, 1'b0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        i_byte_valid = 1'b0;
        chk("midrst_addr", o_imem_addr, BASE);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_hold", o_cpu_hold, 1);
        chk("midrst_ready", o_byte_ready, 0);
        @(negedge clk);
        wq.delete();
        wq.push_back(32'hAABB_CCDD);
        run_load(16'd1, 0, 0);

        // i_start during DATA is ignored
        fill_random(2);
        do_start();
        send_byte(8'h00, 0, 1'b0, 0, 0);
        send_byte(8'h02, 0, 1'b0, 0, 0);
        send_byte(wq[0][31:24], 0, 1'b0, 0, 0);
        send_byte(wq[0][23:16], 0, 1'b0, 0, 0);
        i_byte_valid = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_in_data_busy",  o_busy, 1);
        chk("start_in_data_ready", o_byte_ready, 1);
        send_byte(wq[0][15:8], 0, 1'b0, 0, 0);
        send_byte(wq[0][7:0],  0, 1'b1, BASE, wq[0]);
        for (int b = 0; b < 4; b++)
            send_byte(wq[1][31-8*b -: 8], 0, b == 3, BASE + 32'd4, wq[1]);
        i_byte_valid = 1'b0;
        wait_end(1'b0);

        // i_start in DONE re-asserts hold on the next cycle
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("restart_hold", o_cpu_hold, 1);
        chk("restart_done", o_done, 0);
        chk("restart_busy", o_busy, 1);

        // Randomized loads (the pending LEN_HI absorbs the next start)
        for (int it = 0; it < 8; it++) begin
            int n;
            n = rg(1, 6);
            fill_random(n);
            run_load(16'(n), 0, 3);
        end

        // Largest accepted length
        fill_random(MAXW);
        run_load(16'(MAXW), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
